// File: rtl/noc_eject_pkg.sv
`default_nettype none
// ============================================================================
// Module : noc_eject_pkg
// Flit type codes and default geometry shared by the ejection interface.
// Rev    : 1.0
// ============================================================================
package noc_eject_pkg;

    localparam int NOC_DATAW = 34;
    localparam int NOC_VCH   = 4;
    localparam int NOC_VCHW  = 2;
    localparam int NOC_DEPTH = 4;

    typedef enum logic [1:0] {
        FT_NONE = 2'b00,
        FT_HEAD = 2'b01,
        FT_TAIL = 2'b10,
        FT_DATA = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } ej_state_e;

endpackage
`default_nettype wire

// File: rtl/noc_ej_fifo.sv
`default_nettype none
// ============================================================================
// Module : noc_ej_fifo
// Single-clock show-ahead FIFO with occupancy count; head visible combinationally.
// Rev    : 1.0
// ============================================================================
module noc_ej_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic                       wr_en_i,
    input  logic [W-1:0]               wr_data_i,
    input  logic                       rd_en_i,
    output logic [W-1:0]               rd_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;
    logic         w_wr_ok;
    logic         w_rd_ok;

    assign empty_o   = (wptr_q == rptr_q);
    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o   = wptr_q - rptr_q;
    assign rd_data_o = mem_q[rptr_q[AW-1:0]];
    assign w_wr_ok   = wr_en_i && !full_o;
    assign w_rd_ok   = rd_en_i && !empty_o;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_wr_ok) wptr_q <= wptr_q + PTR_ONE;
            if (w_rd_ok) rptr_q <= rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/noc_eject.sv
`default_nettype none
// ============================================================================
// Module : noc_eject
// Ejection NI: per-VC FIFOs, ack/lock to router, packet-atomic delivery to core.
// Optional statistics counters enabled by NOC_EJ_STATS_EN.
// Rev    : 1.0
// ============================================================================
module noc_eject
    import noc_eject_pkg::*;
#(
    parameter int DATAW = NOC_DATAW,
    parameter int VCH   = NOC_VCH,
    parameter int VCHW  = NOC_VCHW,
    parameter int DEPTH = NOC_DEPTH
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DATAW-1:0] idata,
    input  logic             ivalid,
    input  logic [VCHW-1:0]  ivch,
    output logic [VCH-1:0]   oack,
    output logic [VCH-1:0]   olck,
    output logic [31:0]      pkt_data,
    output logic [1:0]       pkt_type,
    output logic [VCHW-1:0]  pkt_vch,
    output logic             pkt_valid,
    input  logic             pkt_ready,
    output logic             err_ovf,
    output logic             err_proto,
    output logic [15:0]      stat_pkts,
    output logic [15:0]      stat_flits
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0] ACK_MAX = (AW+1)'(DEPTH - 2);

    logic [DATAW-1:0] w_head [VCH];
    logic [AW:0]      w_cnt  [VCH];
    logic [VCH-1:0]   w_empty, w_full, w_wr_en, w_rd_en, w_cand;
    logic [1:0]       w_in_type, w_pop_type;
    logic             w_wr_req, w_arb_found, w_valid, w_pop;
    logic [VCHW-1:0]  w_arb_vc, w_idx, w_sel;

    logic [AW:0]      w_cnt_nxt;
    logic             w_hd_wr, w_hd_rd, w_tl_rd, w_proto_hit;
    logic [VCH-1:0]   w_ack_d, w_lck_d;
    logic [AW:0]      hcnt_d [VCH];

    ej_state_e        state_q;
    logic [VCHW-1:0]  lock_q, last_q;
    logic [VCH-1:0]   oack_q, olck_q;
    logic [AW:0]      hcnt_q [VCH];
    logic             err_ovf_q, err_proto_q;

    assign w_in_type = idata[DATAW-1 -: 2];
    assign w_wr_req  = ivalid && (w_in_type != FT_NONE);

    for (genvar v = 0; v < VCH; v++) begin : g_vc
        assign w_wr_en[v] = w_wr_req && (ivch == VCHW'(v)) && !w_full[v];
        assign w_rd_en[v] = w_pop && (w_sel == VCHW'(v));

        noc_ej_fifo #(
            .W     (DATAW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_      (rst_),
            .wr_en_i   (w_wr_en[v]),
            .wr_data_i (idata),
            .rd_en_i   (w_rd_en[v]),
            .rd_data_o (w_head[v]),
            .empty_o   (w_empty[v]),
            .full_o    (w_full[v]),
            .count_o   (w_cnt[v])
        );
    end

    // Round-robin over VCs presenting a HEAD, starting just after the last VC served.
    always_comb begin
        w_cand      = '0;
        w_arb_found = 1'b0;
        w_arb_vc    = '0;
        w_idx       = '0;
        for (int v = 0; v < VCH; v++) begin
            w_cand[v] = !w_empty[v] && (w_head[v][DATAW-1 -: 2] == FT_HEAD);
        end
        for (int i = 1; i <= VCH; i++) begin
            w_idx = VCHW'((int'(last_q) + i) % VCH);
            if (!w_arb_found && w_cand[w_idx]) begin
                w_arb_found = 1'b1;
                w_arb_vc    = w_idx;
            end
        end
    end

    assign w_sel      = (state_q == ST_STREAM) ? lock_q : w_arb_vc;
    assign w_valid    = (state_q == ST_STREAM) ? !w_empty[lock_q] : w_arb_found;
    assign w_pop      = w_valid && pkt_ready;
    assign w_pop_type = w_head[w_sel][DATAW-1 -: 2];

    assign pkt_valid  = w_valid;
    assign pkt_data   = w_valid ? w_head[w_sel][31:0] : '0;
    assign pkt_type   = w_valid ? w_pop_type : 2'b00;
    assign pkt_vch    = w_valid ? w_sel : '0;

    always_comb begin
        w_cnt_nxt   = '0;
        w_hd_wr     = 1'b0;
        w_hd_rd     = 1'b0;
        w_tl_rd     = 1'b0;
        w_proto_hit = 1'b0;
        w_ack_d     = '0;
        w_lck_d     = '0;
        for (int v = 0; v < VCH; v++) begin
            hcnt_d[v] = hcnt_q[v];
        end
        for (int v = 0; v < VCH; v++) begin
            w_cnt_nxt = w_cnt[v];
            if (w_wr_en[v] && !w_rd_en[v])      w_cnt_nxt = w_cnt[v] + CNT_ONE;
            else if (!w_wr_en[v] && w_rd_en[v]) w_cnt_nxt = w_cnt[v] - CNT_ONE;
            w_ack_d[v] = (w_cnt_nxt <= ACK_MAX);

            w_hd_wr = w_wr_en[v] && (w_in_type == FT_HEAD);
            w_hd_rd = w_rd_en[v] && (w_pop_type == FT_HEAD);
            w_tl_rd = w_rd_en[v] && (w_pop_type == FT_TAIL);
            if (w_hd_wr && !w_hd_rd)      hcnt_d[v] = hcnt_q[v] + CNT_ONE;
            else if (!w_hd_wr && w_hd_rd) hcnt_d[v] = hcnt_q[v] - CNT_ONE;

            w_lck_d[v] = w_hd_wr ? 1'b1 : (w_tl_rd ? 1'b0 : olck_q[v]);

            // A body flit is legal while a HEAD for it is still queued, even if unlocked.
            if (w_wr_en[v] && (w_in_type == FT_HEAD) && olck_q[v])
                w_proto_hit = 1'b1;
            if (w_wr_en[v] && (w_in_type != FT_HEAD) && !olck_q[v] && (hcnt_q[v] == '0))
                w_proto_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            lock_q  <= '0;
            last_q  <= VCHW'(VCH - 1);
        end else if (w_pop) begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_STREAM;
                    lock_q  <= w_sel;
                    last_q  <= w_sel;
                end
                ST_STREAM: begin
                    if (w_pop_type == FT_TAIL) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            oack_q      <= '1;
            olck_q      <= '0;
            err_ovf_q   <= 1'b0;
            err_proto_q <= 1'b0;
            for (int v = 0; v < VCH; v++) hcnt_q[v] <= '0;
        end else begin
            oack_q      <= w_ack_d;
            olck_q      <= w_lck_d;
            err_ovf_q   <= err_ovf_q | (w_wr_req && w_full[ivch]);
            err_proto_q <= err_proto_q | w_proto_hit;
            for (int v = 0; v < VCH; v++) hcnt_q[v] <= hcnt_d[v];
        end
    end

    assign oack      = oack_q;
    assign olck      = olck_q;
    assign err_ovf   = err_ovf_q;
    assign err_proto = err_proto_q;

`ifdef NOC_EJ_STATS_EN
    logic [15:0] stat_pkts_q, stat_flits_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            stat_pkts_q  <= '0;
            stat_flits_q <= '0;
        end else if (w_pop) begin
            stat_flits_q <= stat_flits_q + 16'd1;
            if (w_pop_type == FT_TAIL) stat_pkts_q <= stat_pkts_q + 16'd1;
        end
    end

    assign stat_pkts  = stat_pkts_q;
    assign stat_flits = stat_flits_q;
`else
    assign stat_pkts  = '0;
    assign stat_flits = '0;
`endif

endmodule
`default_nettype wire
